// File: rtl/fact_scheduler.sv
// Job scheduler for the factorial accelerator: queues CPU operands, runs each
// one through the accelerator register interface and queues {err, result}.
module fact_scheduler #(
  parameter int JDEPTH  = 4,
  parameter int RDEPTH  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        job_we_i,
  input  logic [3:0]  job_n_i,
  output logic        job_full_o,
  output logic        ovf_o,
  output logic        res_valid_o,
  output logic [31:0] res_data_o,
  output logic        res_err_o,
  input  logic        res_re_i,
  output logic        busy_o,
  output logic [1:0]  fact_a_o,
  output logic        fact_we_o,
  output logic [3:0]  fact_wd_o,
  input  logic [31:0] fact_rd_i
);

  // state | meaning
  // IDLE  | wait for a job and a free result slot
  // LOAD  | write n to the accelerator
  // GO    | set go, clear poll timer
  // POLL  | read status until done or timeout
  // READ  | read result, push {err, result}
  // CLEAR | clear go
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_GO, S_POLL, S_READ, S_CLEAR
  } state_e;

  localparam int JAW = $clog2(JDEPTH);
  localparam int RAW = $clog2(RDEPTH);
  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  state_e state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [3:0]  n_q, n_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;

  logic [3:0]  jmem_q [JDEPTH];
  logic [JAW:0] jwptr_q, jwptr_d, jrptr_q, jrptr_d;
  logic [32:0] rmem_q [RDEPTH];
  logic [RAW:0] rwptr_q, rwptr_d, rrptr_q, rrptr_d;

  logic job_empty, job_full, job_push, job_pop;
  logic res_empty, res_full, res_push, res_pop;
  logic [32:0] res_wdata;

  assign job_empty = (jwptr_q == jrptr_q);
  assign job_full  = (jwptr_q[JAW] != jrptr_q[JAW]) &&
                     (jwptr_q[JAW-1:0] == jrptr_q[JAW-1:0]);
  assign res_empty = (rwptr_q == rrptr_q);
  assign res_full  = (rwptr_q[RAW] != rrptr_q[RAW]) &&
                     (rwptr_q[RAW-1:0] == rrptr_q[RAW-1:0]);

  assign job_push = job_we_i && !job_full;
  assign res_pop  = res_re_i && !res_empty;

  assign jwptr_d = job_push ? jwptr_q + 1'b1 : jwptr_q;
  assign jrptr_d = job_pop  ? jrptr_q + 1'b1 : jrptr_q;
  assign rwptr_d = res_push ? rwptr_q + 1'b1 : rwptr_q;
  assign rrptr_d = res_pop  ? rrptr_q + 1'b1 : rrptr_q;
  assign ovf_d   = ovf_q || (job_we_i && job_full);

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      n_q     <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      jwptr_q <= '0;
      jrptr_q <= '0;
      rwptr_q <= '0;
      rrptr_q <= '0;
      for (int i = 0; i < JDEPTH; i++) jmem_q[i] <= '0;
      for (int i = 0; i < RDEPTH; i++) rmem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      n_q     <= n_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      jwptr_q <= jwptr_d;
      jrptr_q <= jrptr_d;
      rwptr_q <= rwptr_d;
      rrptr_q <= rrptr_d;
      if (job_push) jmem_q[jwptr_q[JAW-1:0]] <= job_n_i;
      if (res_push) rmem_q[rwptr_q[RAW-1:0]] <= res_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    n_d       = n_q;
    err_d     = err_q;
    job_pop   = 1'b0;
    res_push  = 1'b0;
    res_wdata = '0;
    unique case (state_q)
      S_IDLE: begin
        if (!job_empty && !res_full) begin
          job_pop = 1'b1;
          n_d     = jmem_q[jrptr_q[JAW-1:0]];
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_GO;
      S_GO: begin
        timer_d = '0;
        state_d = S_POLL;
      end
      S_POLL: begin
        if (fact_rd_i[0]) begin
          err_d   = fact_rd_i[1];
          state_d = S_READ;
        end else if (timer_q == TMAX) begin
          res_push  = 1'b1;
          res_wdata = {1'b1, 32'h0};
          state_d   = S_CLEAR;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_READ: begin
        res_push  = 1'b1;
        res_wdata = {err_q, fact_rd_i};
        state_d   = S_CLEAR;
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fact_a_o  = 2'd2;
    fact_we_o = 1'b0;
    fact_wd_o = 4'd0;
    unique case (state_q)
      S_LOAD: begin
        fact_a_o  = 2'd0;
        fact_we_o = 1'b1;
        fact_wd_o = n_q;
      end
      S_GO: begin
        fact_a_o  = 2'd1;
        fact_we_o = 1'b1;
        fact_wd_o = 4'd1;
      end
      S_READ:  fact_a_o = 2'd3;
      S_CLEAR: begin
        fact_a_o  = 2'd1;
        fact_we_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign job_full_o  = job_full;
  assign ovf_o       = ovf_q;
  assign res_valid_o = !res_empty;
  assign res_data_o  = rmem_q[rrptr_q[RAW-1:0]][31:0];
  assign res_err_o   = rmem_q[rrptr_q[RAW-1:0]][32];

endmodule
